// File: rtl/xma_coef_ctrl.sv
// Coefficient controller: software-writable shadow bank, copied atomically into the
// active bank on the first sync after a commit. Optional readback port: XMA_COEF_READBACK_EN.
module xma_coef_ctrl #(
  parameter int          NQDRV   = 4,
  parameter int          TIMEOUT = 65535,
  parameter logic [31:0] UNITY   = 32'h7FFF_0000,
  localparam int         IW      = (NQDRV > 1) ? $clog2(NQDRV) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [IW-1:0]             wr_row,
  input  logic [IW-1:0]             wr_col,
  input  logic [31:0]               wr_data,
  input  logic                      commit,
  input  logic                      sync,
`ifdef XMA_COEF_READBACK_EN
  input  logic [IW-1:0]             rd_row,
  input  logic [IW-1:0]             rd_col,
  input  logic                      rd_bank,
  output logic [31:0]               rd_data,
`endif
  output logic [NQDRV*NQDRV*32-1:0] coef,
  output logic                      busy,
  output logic                      swap_done,
  output logic                      timeout,
  output logic                      wr_err,
  output logic [7:0]                err_cnt
);

  localparam int             CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW:0]    NQ_W     = (IW+1)'(NQDRV);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   shadow [NQDRV][NQDRV];
  logic [31:0]   active [NQDRV][NQDRV];
  logic          wr_in_range, wr_ok, wr_rej, do_swap, do_abort;

  assign wr_in_range = ({1'b0, wr_row} < NQ_W) && ({1'b0, wr_col} < NQ_W);
  assign busy        = (state_q == PENDING);

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    wr_ok    = 1'b0;
    wr_rej   = 1'b0;
    do_swap  = 1'b0;
    do_abort = 1'b0;
    case (state_q)
      IDLE: begin
        wr_ok  = wr_en && wr_in_range;
        wr_rej = wr_en && !wr_in_range;
        if (commit) state_d = PENDING;
      end
      PENDING: begin
        wr_rej = wr_en;
        if (sync) begin
          do_swap = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          do_abort = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      swap_done <= 1'b0;
      timeout   <= 1'b0;
      wr_err    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      // Held at zero in IDLE, so the count starts from 0 on the commit edge.
      cnt_q     <= (state_q == IDLE) ? '0 : cnt_q + 1'b1;
      swap_done <= do_swap;
      timeout   <= do_abort;
      wr_err    <= wr_rej;
      if (wr_rej && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  // NOTE: both banks are flop arrays, not RAM, so they take the identity reset directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NQDRV; i++)
        for (int j = 0; j < NQDRV; j++) begin
          shadow[i][j] <= (i == j) ? UNITY : 32'h0;
          active[i][j] <= (i == j) ? UNITY : 32'h0;
        end
    end else begin
      if (wr_ok) shadow[wr_row][wr_col] <= wr_data;
      // Swap and accepted writes are exclusive by state, so the copy sees a stable shadow.
      if (do_swap)
        for (int i = 0; i < NQDRV; i++)
          for (int j = 0; j < NQDRV; j++)
            active[i][j] <= shadow[i][j];
    end
  end

  always_comb begin
    coef = '0;
    for (int i = 0; i < NQDRV; i++)
      for (int j = 0; j < NQDRV; j++)
        coef[(i*NQDRV+j)*32 +: 32] = active[i][j];
  end

`ifdef XMA_COEF_READBACK_EN
  logic rd_in_range;
  assign rd_in_range = ({1'b0, rd_row} < NQ_W) && ({1'b0, rd_col} < NQ_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              rd_data <= '0;
    else if (!rd_in_range) rd_data <= '0;
    else                  rd_data <= rd_bank ? active[rd_row][rd_col] : shadow[rd_row][rd_col];
  end
`endif

endmodule

// File: tb/tb_xma_coef_ctrl.sv
// Directed bench for xma_coef_ctrl (NQDRV=3, TIMEOUT=16) with a swap scoreboard.
module tb_xma_coef_ctrl;

  localparam int          NQ    = 3;
  localparam int          TO    = 16;
  localparam int          IW    = 2;
  localparam int          NE    = NQ * NQ;
  localparam logic [31:0] UNITY = 32'h7FFF_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en, commit, sync;
  logic [IW-1:0]     wr_row, wr_col;
  logic [31:0]       wr_data;
  logic [NE*32-1:0]  coef;
  logic              busy, swap_done, timeout, wr_err;
  logic [7:0]        err_cnt;
`ifdef XMA_COEF_READBACK_EN
  logic [IW-1:0]     rd_row, rd_col;
  logic              rd_bank;
  logic [31:0]       rd_data;
`endif

  xma_coef_ctrl #(.NQDRV(NQ), .TIMEOUT(TO), .UNITY(UNITY)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .commit(commit), .sync(sync),
`ifdef XMA_COEF_READBACK_EN
    .rd_row(rd_row), .rd_col(rd_col), .rd_bank(rd_bank), .rd_data(rd_data),
`endif
    .coef(coef), .busy(busy), .swap_done(swap_done), .timeout(timeout),
    .wr_err(wr_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int               n_asserts = 0;
  int               n_fails   = 0;
  logic [NE*32-1:0] sh_m, act_m, ident;
  logic [NE*32-1:0] exp_q [$];

  function automatic logic [NE*32-1:0] identity();
    logic [NE*32-1:0] v = '0;
    for (int i = 0; i < NQ; i++) v[(i*NQ+i)*32 +: 32] = UNITY;
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_coef(input string tag, input logic [NE*32-1:0] exp);
    for (int i = 0; i < NQ; i++)
      for (int j = 0; j < NQ; j++)
        check($sformatf("%s(%0d,%0d)", tag, i, j), coef[(i*NQ+j)*32 +: 32], exp[(i*NQ+j)*32 +: 32]);
  endtask

  // Called on the cycle after a sync edge in PENDING: the swap must be visible now.
  task automatic expect_swap(input string tag);
    logic [NE*32-1:0] e;
    check({tag, "_swap_done"}, 32'(swap_done), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_coef({tag, "_coef"}, e);
      act_m = e;
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic put_wr(input int r, input int c, input logic [31:0] d);
    wr_en = 1'b1; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
  endtask

  initial begin
    rst = 1'b1; wr_en = 0; commit = 0; sync = 0; wr_row = 0; wr_col = 0; wr_data = 0;
`ifdef XMA_COEF_READBACK_EN
    rd_row = 0; rd_col = 0; rd_bank = 0;
`endif
    ident = identity();
    sh_m  = ident;
    act_m = ident;
    step(); step();
    rst = 1'b0;
    step();

    // Reset values
    check("rst_coef00", coef[31:0], UNITY);
    check("rst_coef01", coef[63:32], 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_pulses", {29'd0, swap_done, timeout, wr_err}, 32'd0);
    check_coef("rst", act_m);

    // Basic swap: sync five cycles after commit
    put_wr(1, 2, 32'h1234_ABCD);
    sh_m[(1*NQ+2)*32 +: 32] = 32'h1234_ABCD;
    step(); wr_en = 0;
    check("basic_wr_err", 32'(wr_err), 32'd0);
    commit = 1; step(); commit = 0;
    check("basic_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("basic_pre_swap_done", 32'(swap_done), 32'd0);
      check("basic_pre_coef12", coef[(1*NQ+2)*32 +: 32], act_m[(1*NQ+2)*32 +: 32]);
      step();
    end
    sync = 1; exp_q.push_back(sh_m); step(); sync = 0;
    expect_swap("basic");
    check("basic_coef12", coef[(1*NQ+2)*32 +: 32], 32'h1234_ABCD);
    step();
    check("basic_pulse_once", 32'(swap_done), 32'd0);
`ifdef XMA_COEF_READBACK_EN
    rd_row = 1; rd_col = 2; rd_bank = 0; step();
    check("rb_shadow12", rd_data, 32'h1234_ABCD);
`endif

    // Write during PENDING is rejected
    commit = 1; step(); commit = 0;
    check("pend_busy", 32'(busy), 32'd1);
    put_wr(0, 0, 32'h0001_0001); step(); wr_en = 0;
    check("pend_wr_err", 32'(wr_err), 32'd1);
    check("pend_err_cnt", 32'(err_cnt), 32'd1);
    step();
    check("pend_wr_err_pulse", 32'(wr_err), 32'd0);
    sync = 1; exp_q.push_back(sh_m); step(); sync = 0;
    expect_swap("pend");
    check("pend_coef00", coef[31:0], UNITY);

    // Timeout with no sync
    commit = 1; step(); commit = 0;
    for (int k = 1; k < TO; k++) begin
      step();
      check("to_early", {30'd0, timeout, busy}, 32'd1);
    end
    step();
    check("to_pulse", 32'(timeout), 32'd1);
    check("to_busy", 32'(busy), 32'd0);
    check_coef("to", act_m);
    step();
    check("to_pulse_once", 32'(timeout), 32'd0);
    sync = 1; step(); sync = 0;
    check("to_late_sync", 32'(swap_done), 32'd0);
    check_coef("to_late", act_m);

    // Write and commit in the same cycle
    put_wr(2, 0, 32'hCAFE_0001); commit = 1;
    sh_m[(2*NQ+0)*32 +: 32] = 32'hCAFE_0001;
    step(); wr_en = 0; commit = 0;
    check("wc_wr_err", 32'(wr_err), 32'd0);
    check("wc_busy", 32'(busy), 32'd1);
    sync = 1; exp_q.push_back(sh_m); step(); sync = 0;
    expect_swap("wc");

    // Commit and sync in the same IDLE cycle: that sync is not used
    put_wr(2, 1, 32'h0BAD_F00D);
    sh_m[(2*NQ+1)*32 +: 32] = 32'h0BAD_F00D;
    step(); wr_en = 0;
    commit = 1; sync = 1; step(); commit = 0; sync = 0;
    check("cs_no_swap", 32'(swap_done), 32'd0);
    check("cs_busy", 32'(busy), 32'd1);
    check_coef("cs_hold", act_m);
    step();
    sync = 1; exp_q.push_back(sh_m); step(); sync = 0;
    expect_swap("cs");

    // Out-of-range indices are rejected in IDLE
    put_wr(3, 0, 32'hDEAD_0000); step(); wr_en = 0;
    check("oor_row_err", 32'(wr_err), 32'd1);
    check("oor_row_cnt", 32'(err_cnt), 32'd2);
    put_wr(0, 3, 32'hDEAD_0001); step(); wr_en = 0;
    check("oor_col_err", 32'(wr_err), 32'd1);
    check("oor_col_cnt", 32'(err_cnt), 32'd3);
    commit = 1; step(); commit = 0;
    sync = 1; exp_q.push_back(sh_m); step(); sync = 0;
    expect_swap("oor");

    // Reset while PENDING
    commit = 1; step(); commit = 0;
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1; step();
    sh_m = ident; act_m = ident;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_err_cnt", 32'(err_cnt), 32'd0);
    check_coef("mid_rst", act_m);
    rst = 0; step();
`ifdef XMA_COEF_READBACK_EN
    rd_row = 1; rd_col = 2; rd_bank = 0; step();
    check("rb_rst_shadow12", rd_data, 32'h0);
`endif
    commit = 1; step(); commit = 0;
    sync = 1; exp_q.push_back(sh_m); step(); sync = 0;
    expect_swap("post_rst");
    check("post_rst_coef12", coef[(1*NQ+2)*32 +: 32], 32'h0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
